// File: rtl/port_serializer.sv
// Show-ahead FIFO to serial-frame converter: pops one word, shifts it out LSB first
// with active-low frame/valid strobes, then holds off for a fixed idle gap.
module port_serializer #(
    parameter int unsigned PAYLOAD_W  = 32,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic                 rdy,
    output logic                 pop,
    output logic                 frameo_n,
    output logic                 valido_n,
    output logic                 dout,
    output logic                 busy
);

    localparam int unsigned     CntW      = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
    localparam logic [CntW-1:0] LastBit   = CntW'(PAYLOAD_W - 1);
    localparam logic [CntW-1:0] PenultBit = CntW'(PAYLOAD_W - 2);
    localparam logic [3:0]      LastGap   = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   sr_q, sr_d;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]             gap_cnt_q, gap_cnt_d;
    logic                   dout_q, dout_d;
    logic                   frameo_n_q, frameo_n_d;
    logic                   valido_n_q, valido_n_d;
    logic                   busy_q, busy_d;
    logic                   take;

    // Serial outputs are computed one cycle ahead and registered, so the
    // cycle after the pop already carries bit 0.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        dout_d     = 1'b0;
        frameo_n_d = 1'b1;
        valido_n_d = 1'b1;
        take       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rdy) begin
                    take       = 1'b1;
                    sr_d       = payload;
                    bit_cnt_d  = '0;
                    state_d    = StSend;
                    dout_d     = payload[0];
                    valido_n_d = 1'b0;
                    frameo_n_d = 1'b0;
                end
            end
            StSend: begin
                if (bit_cnt_q == LastBit) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end else begin
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    sr_d       = sr_q >> 1;
                    dout_d     = sr_q[1];
                    valido_n_d = 1'b0;
                    frameo_n_d = (bit_cnt_q == PenultBit);
                end
            end
            StGap: begin
                if (gap_cnt_q == LastGap) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    // Gated by reset so no dequeue can leak out while the block is held in reset.
    assign pop = take & reset_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            dout_q     <= 1'b0;
            frameo_n_q <= 1'b1;
            valido_n_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            dout_q     <= dout_d;
            frameo_n_q <= frameo_n_d;
            valido_n_q <= valido_n_d;
            busy_q     <= busy_d;
        end
    end

    assign dout     = dout_q;
    assign frameo_n = frameo_n_q;
    assign valido_n = valido_n_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_port_serializer.sv
// Directed bench for port_serializer: a default (32/1) and a narrow (8/3) instance,
// checked cycle by cycle against a scoreboard of expected serial symbols.
module tb_port_serializer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] payload;
    logic        rdy;
    logic        pop, frameo_n, valido_n, dout, busy;
    logic [7:0]  payload8;
    logic        rdy8;
    logic        pop8, frameo8_n, valido8_n, dout8, busy8;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_prev;

    // Entries are {dout, frameo_n, valido_n} expected on successive cycles.
    logic [2:0] q0[$];
    logic [2:0] q1[$];
    int         pops0[$];
    int         pops1[$];

    always #5 clock = ~clock;

    port_serializer #(.PAYLOAD_W(32), .GAP_CYCLES(1)) u_dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .payload  (payload),
        .rdy      (rdy),
        .pop      (pop),
        .frameo_n (frameo_n),
        .valido_n (valido_n),
        .dout     (dout),
        .busy     (busy)
    );

    port_serializer #(.PAYLOAD_W(8), .GAP_CYCLES(3)) u_dut8 (
        .clock    (clock),
        .reset_n  (reset_n),
        .payload  (payload8),
        .rdy      (rdy8),
        .pop      (pop8),
        .frameo_n (frameo8_n),
        .valido_n (valido8_n),
        .dout     (dout8),
        .busy     (busy8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: check registered outputs, apply new inputs, then check pop.
    task automatic step(input logic r0, input logic [31:0] p0,
                        input logic r1, input logic [7:0] p1);
        logic       e0, e1, xp0, xp1;
        logic [2:0] x0, x1;
        @(negedge clock);
        cyc++;
        e0 = (q0.size() == 0);
        e1 = (q1.size() == 0);
        x0 = 3'b011;
        x1 = 3'b011;
        if (!e0) x0 = q0.pop_front();
        if (!e1) x1 = q1.pop_front();
        chk("busy", busy, !e0);
        chk("serial", {dout, frameo_n, valido_n}, x0);
        chk("busy8", busy8, !e1);
        chk("serial8", {dout8, frameo8_n, valido8_n}, x1);
        rdy      = r0;
        payload  = p0;
        rdy8     = r1;
        payload8 = p1;
        #1;
        xp0 = r0 && e0 && reset_n;
        xp1 = r1 && e1 && reset_n;
        chk("pop", pop, xp0);
        chk("pop8", pop8, xp1);
        if (pop)  pops0.push_back(cyc);
        if (pop8) pops1.push_back(cyc);
        if (xp0) begin
            for (int i = 0; i < 32; i++) q0.push_back({p0[i], (i == 31), 1'b0});
            q0.push_back(3'b011);
        end
        if (xp1) begin
            for (int i = 0; i < 8; i++) q1.push_back({p1[i], (i == 7), 1'b0});
            for (int i = 0; i < 3; i++) q1.push_back(3'b011);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_pop", pop, 1'b0);
        chk("rst_serial", {dout, frameo_n, valido_n}, 3'b011);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pop8", pop8, 1'b0);
        chk("rst_serial8", {dout8, frameo8_n, valido8_n}, 3'b011);
        chk("rst_busy8", busy8, 1'b0);
    endtask

    initial begin
        reset_n  = 1'b1;
        rdy      = 1'b1;
        payload  = 32'hFFFF_FFFF;
        rdy8     = 1'b1;
        payload8 = 8'hFF;

        // Reset with upstream ready: nothing may be popped.
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs();
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 8'hFF);
        step(1'b0, 32'h0, 1'b0, 8'h0);
        reset_n = 1'b1;

        // Empty upstream for 100 cycles.
        for (int i = 0; i < 100; i++) step(1'b0, $urandom, 1'b0, 8'($urandom));
        chk("empty_no_pop", pops0.size(), 0);

        // Single word, then drain.
        step(1'b1, 32'hA5A5_0F01, 1'b0, 8'h0);
        for (int i = 0; i < 40; i++) step(1'b0, $urandom, 1'b0, 8'h0);
        chk("single_pops", pops0.size(), 1);

        // Back-to-back frames with rdy held.
        pops0.delete();
        for (int i = 0; i < 80; i++)
            step(pops0.size() < 2, (pops0.size() == 0) ? 32'h0000_0001 : 32'h8000_0000,
                 1'b0, 8'h0);
        chk("b2b_pops", pops0.size(), 2);
        chk("b2b_period", pops0[1] - pops0[0], 34);

        // rdy/payload wiggling during SEND and GAP must not disturb the frame.
        pops0.delete();
        step(1'b1, 32'h1234_5678, 1'b0, 8'h0);
        for (int i = 1; i < 34; i++) step(1'($urandom_range(0, 1)), $urandom, 1'b0, 8'h0);
        step(1'b1, 32'h0F0F_3355, 1'b0, 8'h0);
        for (int i = 0; i < 40; i++) step(1'b0, $urandom, 1'b0, 8'h0);
        chk("glitch_pops", pops0.size(), 2);
        chk("glitch_period", pops0[1] - pops0[0], 34);

        // Reset during bit 10: abort at once, the word is never resent.
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 8'h0);
        for (int i = 0; i < 11; i++) step(1'b0, $urandom, 1'b0, 8'h0);
        chk("pre_rst_busy", busy, 1'b1);
        reset_n = 1'b0;
        rdy     = 1'b1;
        #1;
        check_reset_outputs();
        q0.delete();
        q1.delete();
        n_prev = pops0.size();
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 8'hAA);
        step(1'b0, 32'h0, 1'b0, 8'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b0, $urandom, 1'b0, 8'h0);
        chk("rst_no_retx", pops0.size(), n_prev);

        // Narrow instance: single 8'hC3 then a back-to-back pair.
        pops1.delete();
        step(1'b0, 32'h0, 1'b1, 8'hC3);
        for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b0, 8'($urandom));
        chk("w8_single_pops", pops1.size(), 1);
        pops1.delete();
        for (int i = 0; i < 40; i++) step(1'b0, 32'h0, pops1.size() < 2, 8'h5A);
        chk("w8_pops", pops1.size(), 2);
        chk("w8_period", pops1[1] - pops1[0], 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/port_serializer.md
PORT_SERIALIZER -- requirements
Module: port_serializer

Interface
REQ-001 The block SHALL have parameter PAYLOAD_W, default 32, meaning payload word width in bits (legal 8..64).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1, meaning idle cycles forced after each frame (legal 1..15).
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 payload  input  PAYLOAD_W  head word of the upstream show-ahead FIFO; valid whenever rdy=1.
REQ-006 rdy  input  1  upstream FIFO non-empty.
REQ-007 pop  output  1  one-cycle dequeue strobe to the upstream FIFO.
REQ-008 frameo_n  output  1  serial frame indicator, active low.
REQ-009 valido_n  output  1  serial bit-valid indicator, active low.
REQ-010 dout  output  1  serial data bit.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SEND, GAP.
REQ-013 In IDLE with rdy=1, pop SHALL be 1 for that cycle, payload SHALL be captured into a shift register on the same edge, and the next state SHALL be SEND.
REQ-014 In IDLE with rdy=0, pop SHALL be 0 and the state SHALL hold.
REQ-015 pop SHALL never be 1 outside IDLE or when rdy=0; at most one pop per frame.
REQ-016 Latency: the cycle after pop SHALL carry bit 0 on dout.
REQ-017 In SEND, bits SHALL be driven LSB first, one per cycle, for exactly PAYLOAD_W cycles, counted by a bit counter of width clog2(PAYLOAD_W).
REQ-018 In SEND, valido_n SHALL be 0 on every bit cycle.
REQ-019 In SEND, frameo_n SHALL be 0 on bits 0..PAYLOAD_W-2 and 1 on bit PAYLOAD_W-1 (frame end marked coincident with last bit).
REQ-020 After bit PAYLOAD_W-1 the state SHALL become GAP and remain there for exactly GAP_CYCLES cycles, then return to IDLE.
REQ-021 In IDLE and GAP, frameo_n=1, valido_n=1, dout=0.
REQ-022 Frame period for continuously ready upstream SHALL be 1 + PAYLOAD_W + GAP_CYCLES cycles (34 at defaults).
REQ-023 Changes of rdy or payload during SEND or GAP SHALL have no effect on the frame in flight.
REQ-024 All outputs SHALL be driven from registers, except pop, which is combinational from state and rdy.
REQ-025 The bit counter SHALL reset to 0 on entry to SEND and SHALL not wrap within a frame; the gap counter SHALL reset to 0 on entry to GAP.

Reset
REQ-026 While reset_n=0: state=IDLE, pop=0, frameo_n=1, valido_n=1, dout=0, busy=0, and counters and shift register cleared, asynchronously.
REQ-027 Reset asserted mid-SEND SHALL abort the frame immediately; the popped word SHALL be discarded and never retransmitted.
REQ-028 After reset_n deasserts, the first pop SHALL occur no earlier than the first rising edge with reset_n=1 and rdy=1.

Verification
REQ-029 Single word: rdy=1 for one IDLE cycle with payload=32'hA5A5_0F01 -> one pop; next 32 cycles dout=1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1; frameo_n=0 for 31 cycles then 1 on last bit; valido_n=0 for 32 cycles; then 1 gap cycle idle.
REQ-030 Back-to-back: rdy held 1, payloads 32'h0000_0001 then 32'h8000_0000 -> pops exactly 34 cycles apart; second frame dout=1 only on its bit 31.
REQ-031 Reset mid-frame: reset_n=0 during bit 10 -> outputs idle same cycle; after release with rdy=0, no pop and no serial activity.
REQ-032 rdy glitch: rdy drops to 0 during SEND and returns -> frame completes unchanged; next pop only after GAP.
REQ-033 Parameter sweep: PAYLOAD_W=8, GAP_CYCLES=3, payload=8'hC3 -> dout 1,1,0,0,0,0,1,1; frameo_n high on bit 7; 3 idle cycles; period 12.
REQ-034 Empty upstream: rdy=0 for 100 cycles after reset -> pop=0, busy=0, frameo_n=valido_n=1 throughout.
